// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan controller for a 4-digit common-
// anode 7-segment display with a shared segment decoder.
//
// Each digit slot is BLANK_CYC cycles with every anode off (anti-ghosting),
// followed by DIV cycles with that digit lit. Four slots form a frame. New
// digit values are captured into a shadow register on `load` and moved to
// the display registers only at a frame boundary, so a frame never tears.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   digits[15:0] four BCD nibbles, [3:0] = digit 0 (LSD)
//   load         one-cycle strobe capturing digits/dp_in into the shadow
//   dp_in[3:0]   active-high decimal-point request per digit
//   blank_lz     enable leading-zero blanking (digits 1..3)
//   count[3:0]   nibble for the shared decoder, 4'hF = blank
//   an[3:0]      active-low anode enables, an[i] = digit i
//   dp           active-low decimal point of the lit digit
//   frame_done   one-cycle pulse on the last cycle of each frame
//   dbg_state_o  current FSM state (0 = BLANK, 1 = SHOW)
//
// Handshake: `load` has no ready; it is sampled on every rising edge and
// each high cycle overwrites the shadow with that cycle's digits/dp_in.
module display_scan_ctrl #(
  parameter int DIV       = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  count,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_done,
  output logic        dbg_state_o
);

  localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int TW   = $clog2(MAXC + 1);

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   shadow_q, disp_q;
  logic [3:0]    shadow_dp_q, disp_dp_q;
  logic          pending_q;
  logic          boundary;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BLANK;
      idx_q   <= 2'd0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic; the timer restarts at 0 on every state change
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    timer_d  = timer_q + TW'(1);
    boundary = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (timer_q == TW'(BLANK_CYC - 1)) begin
          state_d = ST_SHOW;
          timer_d = '0;
        end
      end
      ST_SHOW: begin
        if (timer_q == TW'(DIV - 1)) begin
          state_d  = ST_BLANK;
          timer_d  = '0;
          idx_d    = idx_q + 2'd1;
          boundary = (idx_q == 2'd3);
        end
      end
      default: begin
        state_d = ST_BLANK;
        timer_d = '0;
      end
    endcase
  end

  // Shadow / display registers. On a boundary that coincides with a load the
  // display takes the old shadow and the new load stays pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      pending_q   <= 1'b0;
    end else begin
      if (boundary && pending_q) begin
        disp_q    <= shadow_q;
        disp_dp_q <= shadow_dp_q;
      end
      if (load) begin
        shadow_q    <= digits;
        shadow_dp_q <= dp_in;
        pending_q   <= 1'b1;
      end else if (boundary) begin
        pending_q <= 1'b0;
      end
    end
  end

  // Output decode, purely from registered state (plus the live blank_lz)
  logic [3:0] lz;
  logic [3:0] cur_nib;

  always_comb begin
    // lz[i]: digit i and every more-significant digit are zero
    lz[3] = (disp_q[15:12] == 4'd0);
    lz[2] = lz[3] && (disp_q[11:8] == 4'd0);
    lz[1] = lz[2] && (disp_q[7:4]  == 4'd0);
    lz[0] = 1'b0;
    cur_nib = disp_q[{idx_q, 2'b00} +: 4];

    an          = 4'b1111;
    count       = 4'hF;
    dp          = 1'b1;
    frame_done  = boundary;
    dbg_state_o = state_q;
    if (state_q == ST_SHOW && !(blank_lz && lz[idx_q])) begin
      an[idx_q] = 1'b0;
      count     = cur_nib;
      dp        = ~disp_dp_q[idx_q];
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with DIV=4, BLANK_CYC=2.
// Reference model: outputs derived from the cycle position inside the frame
// (arithmetic on a counter since reset) plus frame-level shadow/display
// bookkeeping.
`timescale 1ns/1ps
module tb_display_scan_ctrl;

  localparam int DIV   = 4;
  localparam int BC    = 2;
  localparam int SLOT  = BC + DIV;
  localparam int FRAME = 4 * SLOT;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] digits   = '0;
  logic        load     = 1'b0;
  logic [3:0]  dp_in    = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  count, an;
  logic        dp, frame_done, dbg_state;

  display_scan_ctrl #(.DIV(DIV), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .digits(digits), .load(load), .dp_in(dp_in),
    .blank_lz(blank_lz), .count(count), .an(an), .dp(dp),
    .frame_done(frame_done), .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          t;
  logic [15:0] m_sh, m_disp;
  logic [3:0]  m_shdp, m_dispdp;
  bit          m_pend;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0d, time %0t)", tag, obs, exp, t, $time);
    end
  endtask

  task automatic model_reset();
    t = 0; m_sh = '0; m_disp = '0; m_shdp = '0; m_dispdp = '0; m_pend = 0;
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_an"}, an, 4'b1111);
    check({tag, "_count"}, count, 4'hF);
    check({tag, "_dp"}, dp, 1'b1);
    check({tag, "_fd"}, frame_done, 1'b0);
  endtask

  // Called at a negedge; chk_now also checks that blanking is immediate.
  task automatic do_reset(input bit chk_now);
    rst = 1'b0;
    #1;
    if (chk_now) check_blank("rst_async");
    repeat (2) @(negedge clk);
    check_blank("rst_hold");
    model_reset();
    rst = 1'b1;
  endtask

  // One cycle: drive inputs, check outputs against the model, advance.
  task automatic step(input bit ld, input logic [15:0] dg, input logic [3:0] dpi);
    int p, slot, o;
    bit lit, blanked;
    logic [3:0] e_an, e_cnt;
    logic e_dp;
    load = ld; digits = dg; dp_in = dpi;
    #1;
    p = t % FRAME; slot = p / SLOT; o = p % SLOT;
    lit = (o >= BC);
    blanked = blank_lz && slot > 0 && ((m_disp >> (slot * 4)) == 16'd0);
    e_an = 4'b1111; e_cnt = 4'hF; e_dp = 1'b1;
    if (lit && !blanked) begin
      e_an = ~(4'b0001 << slot);
      e_cnt = 4'((m_disp >> (slot * 4)) & 16'hF);
      e_dp = ~m_dispdp[slot];
    end
    check("an", an, e_an);
    check("count", count, e_cnt);
    check("dp", dp, e_dp);
    check("frame_done", frame_done, (p == FRAME - 1));
    check("state", dbg_state, lit);
    check("an_single", ($countones(~an) <= 1), 1'b1);
    // model update for the coming edge
    if (p == FRAME - 1 && m_pend) begin
      m_disp = m_sh; m_dispdp = m_shdp; m_pend = 0;
    end
    if (ld) begin
      m_sh = dg; m_shdp = dpi; m_pend = 1;
    end
    t++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom_range(0, 15));
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset(1'b0);

    // reset release with zero digits
    idle(3 * FRAME);

    // mid-frame load of 1234
    idle(7);
    step(1'b1, 16'h1234, 4'b0000);
    idle(2 * FRAME);

    // leading-zero blanking, then disabled
    step(1'b1, 16'h0050, 4'b0000);
    blank_lz = 1'b1;
    idle(2 * FRAME);
    blank_lz = 1'b0;
    idle(FRAME);

    // load colliding with the frame boundary
    step(1'b1, 16'h1111, 4'b0000);
    while ((t % FRAME) != FRAME - 1) step(1'b0, 16'h0, 4'b0);
    step(1'b1, 16'h2222, 4'b0000);
    idle(2 * FRAME + 3);

    // decimal point on digit 2
    step(1'b1, 16'h8765, 4'b0100);
    idle(2 * FRAME);

    // reset during digit 2 SHOW with a pending load
    step(1'b1, 16'h9999, 4'b1111);
    while ((t % FRAME) != 2 * SLOT + BC) step(1'b0, 16'h0, 4'b0);
    do_reset(1'b1);
    idle(FRAME + 4);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 399) == 0) do_reset(1'b1);
      step(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 1000: clock cycles a digit is lit per slot; legal range >=1.
REQ-002 SHALL have parameter BLANK_CYC, default 16: all-anodes-off cycles before each slot, for anti-ghosting; legal range >=1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port digits, input, 16 bits: four BCD nibbles; [3:0] is digit 0 (LSD) and [15:12] is digit 3 (MSD).
REQ-006 SHALL have port load, input, 1 bit: a one-cycle strobe that captures digits and dp_in into the shadow registers.
REQ-007 SHALL have port dp_in, input, 4 bits: active-high decimal-point request, one bit per digit.
REQ-008 SHALL have port blank_lz, input, 1 bit: enables leading-zero blanking.
REQ-009 SHALL have port count, output, 4 bits: the nibble fed to the shared 7-segment decoder; 4'hF means blank.
REQ-010 SHALL have port an, output, 4 bits: active-low anode enables; an[i] selects digit i.
REQ-011 SHALL have port dp, output, 1 bit: active-low decimal point for the lit digit.
REQ-012 SHALL have port frame_done, output, 1 bit: a one-cycle pulse at each frame boundary.

Function
REQ-013 SHALL implement a 2-state FSM, BLANK and SHOW, with a slot timer and a 2-bit digit index idx.
- BLANK: an=4'b1111, count=4'hF, dp=1.
- After BLANK_CYC cycles in BLANK, the FSM goes to SHOW.
REQ-014 SHALL, in SHOW, hold the outputs for exactly DIV cycles, then return to BLANK with idx advanced by 1 (idx 3 wraps to 0).
- an = all ones except an[idx]=0.
- count = disp[idx].
- dp = ~disp_dp[idx].
REQ-015 SHALL decode count, an and dp combinationally from registered state only, with no extra output latency; the timer resets to 0 on every state change.
REQ-016 SHALL have a frame length of exactly 4*(BLANK_CYC+DIV) cycles.
REQ-017 SHALL, on a load strobe, copy digits and dp_in into the shadow registers on that edge and set a pending flag.
REQ-018 SHALL handle the frame boundary (the SHOW-to-BLANK transition with idx 3 wrapping to 0) as follows:
- If pending=1, copy shadow to the display registers (disp, disp_dp) and clear pending.
- Pulse frame_done=1 for that one cycle.
- Display contents SHALL never change mid-frame (tear-free).
REQ-019 SHALL resolve load coinciding with a frame boundary as follows: the boundary copies the pre-load shadow value, the shadow takes the new value, and pending remains 1.
REQ-020 SHALL, when blank_lz=1, treat digit i (i=1..3) as blanked if disp[i] and all higher disp nibbles are 0.
- Digit 0 SHALL never be blanked.
- A blanked digit in SHOW gives an=4'b1111, count=4'hF, dp=1.
- Slot timing SHALL be unchanged by blanking.
REQ-021 SHALL pass nibbles 10-15 to count unchanged; the decoder blanks them and no error is flagged.
REQ-022 SHALL never assert more than one an bit low in any cycle.

Reset
REQ-023 SHALL, while rst=0, asynchronously force:
- state BLANK, idx=0, timer=0, pending=0;
- shadow and display registers 0;
- an=4'b1111, count=4'hF, dp=1, frame_done=0.
REQ-024 SHALL, after rst deasserts, start with a BLANK_CYC-cycle BLANK slot for digit 0.
REQ-025 SHALL, on reset asserted mid-slot, blank all outputs immediately with no completion of the slot, and discard any pending load.

Verification (DIV=4, BLANK_CYC=2)
REQ-026 SHALL verify reset release with digits=0: cycles 0-1 have an=1111; cycles 2-5 have an=1110, count=0; the pattern repeats with an=1101/1011/0111; frame_done pulses every 24 cycles.
REQ-027 SHALL verify load: digits=16'h1234 loaded mid-frame, with no change until the next frame_done; from the next frame the digit 0 slot shows count=4, digit 3 count=1.
REQ-028 SHALL verify leading-zero blanking: digits=16'h0050, blank_lz=1 gives digit 3 and digit 2 slots an=1111, count=F; digit 1 count=5; digit 0 count=0; with blank_lz=0, digits 3 and 2 show count=0.
REQ-029 SHALL verify the frame-boundary collision: load 16'h1111, then load 16'h2222 exactly on the frame_done cycle; the next frame shows 1111 and the following frame shows 2222.
REQ-030 SHALL verify the decimal point: dp_in=4'b0100 gives dp=0 only while an=1011, otherwise dp=1.
REQ-031 SHALL verify reset mid-SHOW: rst low during digit 2 SHOW gives an=1111, count=F the same cycle; after release the first slot lit is digit 0, with displayed value 0.
